alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Parametrised successor to the single-cycle ALU control decoder: decodes `aluop`/`func` into an extended ALU operation code and `jr`, and additionally sequences the multi-cycle multiply/divide unit with a non-blocking busy tracker. It sits in the EX stage, between the main control unit and the ALU / HI-LO unit. It raises `stall` only when a later instruction needs HI/LO, or the unit itself, while an operation is still in flight.

## Interface
- `CTRL_W`, 4: width of `alucontrol`. Must be ≥4; encodings are zero-extended.
- `MUL_LAT`, 4: cycles from `md_start` to `hilo_we` for MULT/MULTU. Must be ≥1.
- `DIV_LAT`, 32: cycles from `md_start` to `hilo_we` for DIV/DIVU. Must be ≥1.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  EX-stage instruction valid.
- `flush_i`  in  1  cancel in-flight mul/div; suppress a start this cycle.
- `aluop`  in  2  from main control: 00 add, 01 sub, 10 R-type, 11 and.
- `func`  in  6  instruction funct field.
- `alucontrol`  out  CTRL_W  ALU operation (combinational).
- `jr`  out  1  `func`=001000 and `aluop`=10 (combinational, independent of `valid_i`).
- `illegal`  out  1  R-type with an unsupported funct, while `valid_i` is high.
- `md_start`  out  1  one-cycle pulse that launches the mul/div unit.
- `md_op`  out  2  registered op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `busy`  out  1  registered; high while an operation is in flight.
- `hilo_we`  out  1  one-cycle HI/LO write strobe on completion.
- `stall`  out  1  hold the EX stage and everything upstream (combinational).

## Operation
- `alucontrol` encoding:
  - 0 AND, 1 OR, 2 SLT, 3 ADD, 4 SUB, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 XOR, 10 SLTU.
  - `aluop` 00→ADD, 01→SUB, 11→AND.
  - `aluop` 10 by funct: 100100 AND, 100101 OR, 101010 SLT, 100000/100001 ADD, 100010/100011 SUB, 100111 NOR, 000000 SLL, 000010 SRL, 000011 SRA, 100110 XOR, 101011 SLTU.
  - jr (001000), mfhi (010000), mflo (010010) and mul/div funct codes output ADD with `illegal`=0.
  - Any other funct under `aluop` 10: `alucontrol`=AND and `illegal`=1. The output never latches a previous value.
- Mul/div op = `valid_i` & `aluop`=10 & funct in 011000..011011. HI/LO reader = mfhi or mflo.
- FSM states: IDLE, BUSY. A down-counter of width clog2(max(MUL_LAT, DIV_LAT)) tracks progress.
- IDLE transitions:
  - On a mul/div op with `flush_i`=0: `md_start`=1, latch `md_op`, load count with LAT−1, go to BUSY.
  - `stall`=0 in IDLE.
- BUSY transitions:
  - Count decrements each cycle.
  - When count=0: `hilo_we`=1, go to IDLE.
  - `stall`=1 whenever `valid_i` is high and the instruction is a mul/div op or a HI/LO reader. This includes the completion cycle; the held instruction proceeds in the following IDLE cycle.
- `flush_i` in BUSY: go to IDLE next cycle, no `hilo_we`, count cleared. `flush_i` takes priority over completion in the same cycle.
- Reset values: state IDLE, count 0, `md_op`=00, `busy`=0, `hilo_we`=0. With `valid_i`=0, `md_start`=0 and `stall`=0.

## Timing
- Decode path (`alucontrol`, `jr`, `illegal`): zero latency, combinational.
- Mul/div timing:
  - `md_start` is issued in cycle T.
  - `busy`=1 from T+1 through T+LAT.
  - `hilo_we` is high in cycle T+LAT.
  - State is IDLE at T+LAT+1.
- `stall`, `md_start` and `hilo_we` never rise in the same cycle as an async reset assertion. Reset mid-operation aborts silently, with no `hilo_we`.
- A back-to-back mul/div is stalled until the IDLE cycle after completion, then starts there. Throughput is one op per LAT+1 cycles.

## Configuration
- `ALU_CTRL_DIV_EN` defined: DIV/DIVU decoded as mul/div ops with latency `DIV_LAT`.
- Not defined: funct 011010/011011 are treated as unsupported (`illegal`=1, `alucontrol`=AND, no start). `DIV_LAT` is unused, and the counter is sized from `MUL_LAT` only.

## Structure
- Package `alu_ctrl_pkg` holds:
  - `alucontrol` encodings, funct and `aluop` constants;
  - `md_op` encoding;
  - the FSM state enum.
- Sub-module `md_latency_counter`: loadable down-counter with `load`, `value`, `clear` and `zero`. The FSM and decode stay in `alu_ctrl_seq`.

## Test plan
- Decode sweep: `aluop`=10 with every listed funct → matching code. funct=001000 → `jr`=1, ADD. funct=111111 → AND, `illegal`=1. `aluop`=00/01/11 → 3/4/0.
- MULT (011000), `MUL_LAT`=4, start at cycle 10 → `md_start` at cycle 10, `busy` 11–14, `hilo_we` only at 14, `stall`=0 throughout.
- mfhi presented at cycle 12 during a MULT from cycle 10 → `stall`=1 in cycles 12–14, released at 15.
- DIV at cycle 0 with `DIV_LAT`=32, DIVU presented at cycle 5 → stall 5–32, `md_start` for DIVU at 33, `md_op`=11. Without `ALU_CTRL_DIV_EN` → `illegal`=1, no start.
- `flush_i` at cycle 12 of a MULT started at 10 → IDLE at 13, no `hilo_we`. `flush_i` together with a MULT in IDLE → no `md_start`.
- `rst_n` low at cycle 12 of the same MULT → all registered outputs 0 immediately. No `hilo_we` after release.

Source files
------------

// File: rtl/alu_ctrl_seq_pkg.sv
// alu_ctrl_pkg: shared encodings for the EX-stage ALU control decoder and
// the multiply/divide sequencer (ALU codes, funct/aluop constants, md_op
// encoding and sequencer states).
package alu_ctrl_pkg;

  // ALU operation codes (zero-extended to CTRL_W at the output)
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  // aluop values from the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Mul/div operation, equal to the low two funct bits of the instruction
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/alu_ctrl_seq_md_latency_counter.sv
// md_latency_counter: loadable down-counter that tracks how many cycles a
// mul/div operation still has to run. Counts down to zero and holds there.
module md_latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         clear,
  output logic         zero
);

  logic [W-1:0] count;

  // Clear wins over load so a flush always empties the counter; otherwise
  // count down until zero is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: EX-stage ALU control decoder plus multiply/divide sequencer.
// Decodes aluop/func into alucontrol/jr/illegal combinationally, launches
// the mul/div unit and tracks it with an IDLE/BUSY FSM, stalling later
// instructions that need HI/LO or the unit while an operation is in flight.
// Optional feature macro: ALU_CTRL_DIV_EN (enables DIV/DIVU with DIV_LAT).
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [1:0]        aluop,
  input  logic [5:0]        func,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              jr,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              busy,
  output logic              hilo_we,
  output logic              stall
);

`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Without divide support the divide latency collapses onto the multiply
  // latency, so the counter is sized from MUL_LAT alone.
  localparam int DIV_CNT_LAT = DIV_EN ? DIV_LAT : MUL_LAT;
  localparam int MAX_LAT     = (MUL_LAT > DIV_CNT_LAT) ? MUL_LAT : DIV_CNT_LAT;
  localparam int CNT_W       = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CNT_LAT - 1);

  logic [3:0]       alu_code;
  logic             unsupported;
  logic             is_md_fn;
  logic             is_hilo_fn;
  logic             md_req;
  logic             hilo_rd_req;
  md_state_e        state;
  md_state_e        state_next;
  md_op_e           md_op_q;
  logic             cnt_load;
  logic             cnt_clear;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_value;

  // Instruction decode: every path assigns alu_code, so nothing latches.
  always_comb begin
    alu_code    = ALU_AND;
    unsupported = 1'b0;
    is_md_fn    = 1'b0;
    is_hilo_fn  = 1'b0;
    case (aluop)
      ALUOP_ADD: alu_code = ALU_ADD;
      ALUOP_SUB: alu_code = ALU_SUB;
      ALUOP_AND: alu_code = ALU_AND;
      default: begin
        case (func)
          FN_AND:           alu_code = ALU_AND;
          FN_OR:            alu_code = ALU_OR;
          FN_SLT:           alu_code = ALU_SLT;
          FN_ADD, FN_ADDU:  alu_code = ALU_ADD;
          FN_SUB, FN_SUBU:  alu_code = ALU_SUB;
          FN_NOR:           alu_code = ALU_NOR;
          FN_SLL:           alu_code = ALU_SLL;
          FN_SRL:           alu_code = ALU_SRL;
          FN_SRA:           alu_code = ALU_SRA;
          FN_XOR:           alu_code = ALU_XOR;
          FN_SLTU:          alu_code = ALU_SLTU;
          FN_JR:            alu_code = ALU_ADD;
          FN_MFHI, FN_MFLO: begin
            alu_code   = ALU_ADD;
            is_hilo_fn = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            alu_code = ALU_ADD;
            is_md_fn = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          FN_DIV, FN_DIVU: begin
            alu_code = ALU_ADD;
            is_md_fn = 1'b1;
          end
`endif
          default: begin
            alu_code    = ALU_AND;
            unsupported = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign alucontrol  = CTRL_W'(alu_code);
  assign jr          = (aluop == ALUOP_RTYPE) && (func == FN_JR);
  assign illegal     = valid_i && unsupported;
  assign md_req      = valid_i && is_md_fn;
  assign hilo_rd_req = valid_i && is_hilo_fn;
  assign cnt_value   = func[1] ? DIV_LOAD : MUL_LOAD;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the operation kind at launch so the HI/LO unit sees a stable op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_op_q <= MD_MULT;
    end else if (md_start) begin
      md_op_q <= md_op_e'(func[1:0]);
    end
  end

  // Next state and strobes; a flush beats completion in the same cycle.
  always_comb begin
    state_next = state;
    md_start   = 1'b0;
    hilo_we    = 1'b0;
    stall      = 1'b0;
    cnt_load   = 1'b0;
    cnt_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (md_req && !flush_i) begin
          md_start   = 1'b1;
          cnt_load   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      default: begin
        stall = md_req || hilo_rd_req;
        if (flush_i) begin
          cnt_clear  = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt_zero) begin
          hilo_we    = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  assign busy  = (state == ST_BUSY);
  assign md_op = md_op_q;

  md_latency_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .value (cnt_value),
    .clear (cnt_clear),
    .zero  (cnt_zero)
  );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq. Expected
// HI/LO completions are queued at launch and popped when hilo_we is due.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk;
  logic       rst_n;
  logic       valid_i;
  logic       flush_i;
  logic [1:0] aluop;
  logic [5:0] func;
  logic [3:0] alucontrol;
  logic       jr;
  logic       illegal;
  logic       md_start;
  logic [1:0] md_op;
  logic       busy;
  logic       hilo_we;
  logic       stall;

  typedef struct {
    int         due;
    logic [1:0] op;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
    logic       jr;
  } dec_t;

  exp_t sb[$];
  dec_t dtab[20];
  int   checks;
  int   failures;
  int   cyc;
  int   b;

  alu_ctrl_seq #(
    .CTRL_W  (4),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .aluop      (aluop),
    .func       (func),
    .alucontrol (alucontrol),
    .jr         (jr),
    .illegal    (illegal),
    .md_start   (md_start),
    .md_op      (md_op),
    .busy       (busy),
    .hilo_we    (hilo_we),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic f, input logic [1:0] op, input logic [5:0] fn);
    valid_i = v;
    flush_i = f;
    aluop   = op;
    func    = fn;
  endtask

  // Move to mid-cycle and check hilo_we against the scoreboard.
  task automatic midCycle();
    #4;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      checkOutput("hilo_we_done", hilo_we, 1);
      checkOutput("md_op_done", md_op, sb[0].op);
      void'(sb.pop_front());
    end else begin
      checkOutput("hilo_we_quiet", hilo_we, 0);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    dtab = '{
      '{2'b10, 6'b100100, 4'd0,  1'b0, 1'b0},
      '{2'b10, 6'b100101, 4'd1,  1'b0, 1'b0},
      '{2'b10, 6'b101010, 4'd2,  1'b0, 1'b0},
      '{2'b10, 6'b100000, 4'd3,  1'b0, 1'b0},
      '{2'b10, 6'b100001, 4'd3,  1'b0, 1'b0},
      '{2'b10, 6'b100010, 4'd4,  1'b0, 1'b0},
      '{2'b10, 6'b100011, 4'd4,  1'b0, 1'b0},
      '{2'b10, 6'b100111, 4'd5,  1'b0, 1'b0},
      '{2'b10, 6'b000000, 4'd6,  1'b0, 1'b0},
      '{2'b10, 6'b000010, 4'd7,  1'b0, 1'b0},
      '{2'b10, 6'b000011, 4'd8,  1'b0, 1'b0},
      '{2'b10, 6'b100110, 4'd9,  1'b0, 1'b0},
      '{2'b10, 6'b101011, 4'd10, 1'b0, 1'b0},
      '{2'b10, 6'b001000, 4'd3,  1'b0, 1'b1},
      '{2'b10, 6'b010000, 4'd3,  1'b0, 1'b0},
      '{2'b10, 6'b010010, 4'd3,  1'b0, 1'b0},
      '{2'b10, 6'b111111, 4'd0,  1'b1, 1'b0},
      '{2'b00, 6'b111111, 4'd3,  1'b0, 1'b0},
      '{2'b01, 6'b001000, 4'd4,  1'b0, 1'b0},
      '{2'b11, 6'b100101, 4'd0,  1'b0, 1'b0}
    };

    // Reset state
    rst_n = 1'b0;
    applyStimulus(0, 0, 2'b00, 6'b0);
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_md_op", md_op, 0);
    checkOutput("rst_hilo_we", hilo_we, 0);
    checkOutput("rst_md_start", md_start, 0);
    checkOutput("rst_stall", stall, 0);
    #10;
    rst_n = 1'b1;
    nextCycle();
    cyc = 0;

    // Decode sweep
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, dtab[i].op, dtab[i].fn);
      midCycle();
      checkOutput("dec_alucontrol", alucontrol, dtab[i].code);
      checkOutput("dec_illegal", illegal, dtab[i].ill);
      checkOutput("dec_jr", jr, dtab[i].jr);
      checkOutput("dec_md_start", md_start, 0);
      checkOutput("dec_stall", stall, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 2'b10, 6'b111111);
    midCycle();
    checkOutput("illegal_needs_valid", illegal, 0);
    nextCycle();

    // Plain MULT: start, busy window, single completion, never stalls
    b = cyc;
    applyStimulus(1, 0, 2'b10, 6'b011000);
    sb.push_back('{b + MUL_LAT, 2'b00});
    midCycle();
    checkOutput("mult_start", md_start, 1);
    checkOutput("mult_alu", alucontrol, 3);
    checkOutput("mult_illegal", illegal, 0);
    checkOutput("mult_busy_t", busy, 0);
    checkOutput("mult_stall_t", stall, 0);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      midCycle();
      checkOutput("mult_busy", busy, (k <= MUL_LAT) ? 1 : 0);
      checkOutput("mult_no_restart", md_start, 0);
      checkOutput("mult_stall", stall, 0);
      nextCycle();
    end

    // mfhi during a MULT stalls through completion, released next cycle
    b = cyc;
    applyStimulus(1, 0, 2'b10, 6'b011000);
    sb.push_back('{b + MUL_LAT, 2'b00});
    midCycle();
    checkOutput("mfhi_mult_start", md_start, 1);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    midCycle();
    nextCycle();
    for (int k = 2; k <= MUL_LAT + 1; k++) begin
      applyStimulus(1, 0, 2'b10, 6'b010000);
      midCycle();
      checkOutput("mfhi_stall", stall, (k <= MUL_LAT) ? 1 : 0);
      checkOutput("mfhi_busy", busy, (k <= MUL_LAT) ? 1 : 0);
      nextCycle();
    end

    // Back-to-back MULT then MULTU: second held until the IDLE cycle
    b = cyc;
    applyStimulus(1, 0, 2'b10, 6'b011000);
    sb.push_back('{b + MUL_LAT, 2'b00});
    midCycle();
    checkOutput("b2b_first_start", md_start, 1);
    nextCycle();
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      applyStimulus(1, 0, 2'b10, 6'b011001);
      midCycle();
      checkOutput("b2b_stall", stall, (k <= MUL_LAT) ? 1 : 0);
      checkOutput("b2b_start", md_start, (k == MUL_LAT + 1) ? 1 : 0);
      if (md_start === 1'b1) sb.push_back('{cyc + MUL_LAT, 2'b01});
      nextCycle();
    end
    applyStimulus(0, 0, 2'b00, 6'b0);
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      midCycle();
      checkOutput("b2b_second_busy", busy, (k <= MUL_LAT) ? 1 : 0);
      nextCycle();
    end
    checkOutput("b2b_sb_drained", sb.size(), 0);

`ifdef ALU_CTRL_DIV_EN
    // DIV then DIVU held from T+5: stalled through T+DIV_LAT, starts after
    b = cyc;
    applyStimulus(1, 0, 2'b10, 6'b011010);
    sb.push_back('{b + DIV_LAT, 2'b10});
    midCycle();
    checkOutput("div_start", md_start, 1);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    for (int k = 1; k < 5; k++) begin
      midCycle();
      nextCycle();
    end
    for (int k = 5; k <= DIV_LAT + 1; k++) begin
      applyStimulus(1, 0, 2'b10, 6'b011011);
      midCycle();
      checkOutput("divu_stall", stall, (k <= DIV_LAT) ? 1 : 0);
      checkOutput("divu_start", md_start, (k == DIV_LAT + 1) ? 1 : 0);
      if (md_start === 1'b1) sb.push_back('{cyc + DIV_LAT, 2'b11});
      nextCycle();
    end
    applyStimulus(0, 0, 2'b00, 6'b0);
    midCycle();
    checkOutput("divu_md_op", md_op, 2'b11);
    nextCycle();
    for (int k = 2; k <= DIV_LAT + 1; k++) begin
      midCycle();
      nextCycle();
    end
    checkOutput("div_sb_drained", sb.size(), 0);
`else
    // Divide codes are unsupported in this build
    applyStimulus(1, 0, 2'b10, 6'b011010);
    midCycle();
    checkOutput("div_illegal", illegal, 1);
    checkOutput("div_alu", alucontrol, 0);
    checkOutput("div_no_start", md_start, 0);
    nextCycle();
    applyStimulus(1, 0, 2'b10, 6'b011011);
    midCycle();
    checkOutput("divu_illegal", illegal, 1);
    checkOutput("divu_no_start", md_start, 0);
    checkOutput("div_not_busy", busy, 0);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    midCycle();
    checkOutput("divu_not_busy", busy, 0);
    nextCycle();
`endif

    // Flush two cycles into a MULT: IDLE next cycle, no completion
    b = cyc;
    applyStimulus(1, 0, 2'b10, 6'b011000);
    sb.push_back('{b + MUL_LAT, 2'b00});
    midCycle();
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    midCycle();
    nextCycle();
    applyStimulus(0, 1, 2'b00, 6'b0);
    sb.delete();
    midCycle();
    checkOutput("flush_busy_t", busy, 1);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    for (int k = 3; k <= MUL_LAT + 2; k++) begin
      midCycle();
      checkOutput("flush_idle", busy, 0);
      nextCycle();
    end

    // Flush on the completion cycle wins over hilo_we
    applyStimulus(1, 0, 2'b10, 6'b011000);
    midCycle();
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    for (int k = 1; k < MUL_LAT; k++) begin
      midCycle();
      nextCycle();
    end
    applyStimulus(0, 1, 2'b00, 6'b0);
    midCycle();
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    midCycle();
    checkOutput("flush_done_idle", busy, 0);
    nextCycle();

    // Flush with a MULT in IDLE suppresses the start
    applyStimulus(1, 1, 2'b10, 6'b011000);
    midCycle();
    checkOutput("flush_no_start", md_start, 0);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    midCycle();
    checkOutput("flush_no_busy", busy, 0);
    nextCycle();

    // Async reset in the middle of a MULTU aborts it silently
    b = cyc;
    applyStimulus(1, 0, 2'b10, 6'b011001);
    sb.push_back('{b + MUL_LAT, 2'b01});
    midCycle();
    nextCycle();
    applyStimulus(0, 0, 2'b00, 6'b0);
    midCycle();
    checkOutput("pre_rst_busy", busy, 1);
    checkOutput("pre_rst_md_op", md_op, 2'b01);
    nextCycle();
    applyStimulus(1, 0, 2'b10, 6'b010000);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_md_op", md_op, 0);
    checkOutput("arst_hilo_we", hilo_we, 0);
    checkOutput("arst_stall", stall, 0);
    checkOutput("arst_md_start", md_start, 0);
    midCycle();
    nextCycle();
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 0, 2'b00, 6'b0);
    for (int k = 0; k < MUL_LAT + 2; k++) begin
      midCycle();
      checkOutput("post_rst_busy", busy, 0);
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
